// File: rtl/apb_i2c_completer.sv
// apb_i2c_completer
// APB completer that serves a byte-wide register map to an I2C controller core.
// It decodes its slave-select code, inserts WAIT_CYCLES wait states before the
// one-cycle ready pulse, and buffers transmit and receive bytes in two FIFOs.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   sel, enable, write   APB control (sel == SLAVE_ID addresses this block)
//   addr, wdata          APB register address and write data
//   rdata, ready         registered read data and one-cycle completion pulse
//   i2c_en, i2c_go       CTRL.EN level and one-cycle start pulse
//   i2c_addr             target I2C address (SLVADDR[6:0])
//   i2c_busy             controller busy, reported in STATUS
//   tx_data, tx_valid    TX FIFO head and not-empty flag
//   tx_pop               controller consumes the TX head
//   rx_data, rx_push     received byte and its strobe

module apb_i2c_completer #(
    parameter logic [1:0] SLAVE_ID    = 2'b01,
    parameter int         WAIT_CYCLES = 1,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel,
    input  logic       enable,
    input  logic       write,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ready,
    output logic       i2c_en,
    output logic       i2c_go,
    output logic [6:0] i2c_addr,
    input  logic       i2c_busy,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_pop,
    input  logic [7:0] rx_data,
    input  logic       rx_push
);
    localparam int            PW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [2:0]    LP_WAIT = 3'(WAIT_CYCLES);
    localparam logic [CW-1:0] LP_FULL = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LP_P1   = PW'(1);
    localparam logic [CW-1:0] LP_C1   = CW'(1);

    localparam logic [7:0] A_CTRL    = 8'h00;
    localparam logic [7:0] A_STATUS  = 8'h01;
    localparam logic [7:0] A_TXDATA  = 8'h02;
    localparam logic [7:0] A_RXDATA  = 8'h03;
    localparam logic [7:0] A_SLVADDR = 8'h04;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    state_t        r_state;
    logic [2:0]    r_cnt;
    logic          r_ready, r_en, r_go, r_err, r_ovf;
    logic [7:0]    r_rdata;
    logic [6:0]    r_slv;

    logic [7:0]    r_tx_mem [FIFO_DEPTH];
    logic [PW-1:0] r_tx_rd, r_tx_wr;
    logic [CW-1:0] r_tx_cnt;
    logic [7:0]    r_rx_mem [FIFO_DEPTH];
    logic [PW-1:0] r_rx_rd, r_rx_wr;
    logic [CW-1:0] r_rx_cnt;

    logic w_sel_me, w_complete, w_wr, w_rd;
    logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic w_err_set, w_ovf_set, w_err_clr, w_ovf_clr;
    logic [7:0] w_status, w_rd_val;

    assign w_sel_me   = (sel == SLAVE_ID);
    assign w_complete = (r_state == S_ACCESS) && w_sel_me && (r_cnt == LP_WAIT);
    assign w_wr       = w_complete && write;
    assign w_rd       = w_complete && !write;

    assign w_tx_full  = (r_tx_cnt == LP_FULL);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == LP_FULL);
    assign w_rx_empty = (r_rx_cnt == '0);

    // A push into a full FIFO only succeeds when the same edge frees a slot.
    assign w_tx_pop   = tx_pop && !w_tx_empty;
    assign w_tx_push  = w_wr && (addr == A_TXDATA) && (!w_tx_full || w_tx_pop);
    assign w_rx_pop   = w_rd && (addr == A_RXDATA) && !w_rx_empty;
    assign w_rx_push  = rx_push && (!w_rx_full || w_rx_pop);

    assign w_err_set  = (w_complete && (addr > A_SLVADDR))
                      || (w_wr && (addr == A_TXDATA) && !w_tx_push)
                      || (w_rd && (addr == A_RXDATA) && w_rx_empty);
    assign w_ovf_set  = rx_push && !w_rx_push;
    assign w_err_clr  = w_wr && (addr == A_STATUS) && wdata[5];
    assign w_ovf_clr  = w_wr && (addr == A_STATUS) && wdata[6];

    assign w_status = {1'b0, r_ovf, r_err, i2c_busy,
                       w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

    always_comb begin
        w_rd_val = 8'h00;
        case (addr)
            A_CTRL:    w_rd_val = {7'b0, r_en};
            A_STATUS:  w_rd_val = w_status;
            A_RXDATA:  w_rd_val = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd];
            A_SLVADDR: w_rd_val = {1'b0, r_slv};
            default:   w_rd_val = 8'h00;
        endcase
    end

    // Transfer FSM and register file; sticky flags let a same-edge set win over W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_ready <= 1'b0;
            r_rdata <= 8'h00;
            r_en    <= 1'b0;
            r_go    <= 1'b0;
            r_slv   <= 7'd0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_go    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_sel_me && !enable) r_state <= S_SETUP;
                end
                S_SETUP: begin
                    if (!w_sel_me) begin
                        r_state <= S_IDLE;
                    end else if (enable) begin
                        r_state <= S_ACCESS;
                        r_cnt   <= 3'd0;
                    end
                end
                S_ACCESS: begin
                    if (!w_sel_me) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == LP_WAIT) begin
                        r_state <= S_DONE;
                        r_ready <= 1'b1;
                        if (!write) r_rdata <= w_rd_val;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    // Holding enable here blocks a second completion of the same transfer.
                    if (!enable) r_state <= w_sel_me ? S_SETUP : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_wr && (addr == A_CTRL)) begin
                r_en <= wdata[0];
                r_go <= wdata[1];
            end
            if (w_wr && (addr == A_SLVADDR)) r_slv <= wdata[6:0];
            r_err <= w_err_set || (r_err && !w_err_clr);
            r_ovf <= w_ovf_set || (r_ovf && !w_ovf_clr);
        end
    end

    // FIFO pointers and occupancy counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_rd  <= '0;
            r_tx_wr  <= '0;
            r_tx_cnt <= '0;
            r_rx_rd  <= '0;
            r_rx_wr  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + LP_P1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + LP_P1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + LP_C1;
                2'b01:   r_tx_cnt <= r_tx_cnt - LP_C1;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
            if (w_rx_push) r_rx_wr <= r_rx_wr + LP_P1;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + LP_P1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + LP_C1;
                2'b01:   r_rx_cnt <= r_rx_cnt - LP_C1;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // FIFO storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr] <= wdata;
        if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_data;
    end

    assign rdata    = r_rdata;
    assign ready    = r_ready;
    assign i2c_en   = r_en;
    assign i2c_go   = r_go;
    assign i2c_addr = r_slv;
    assign tx_valid = !w_tx_empty;
    assign tx_data  = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd];

endmodule

// File: tb/tb_apb_i2c_completer.sv
// Testbench for apb_i2c_completer: directed steps plus a randomized phase,
// checked against a queue-based model of the register map.

module tb_apb_i2c_completer;
    localparam logic [1:0] SID   = 2'b01;
    localparam int         WAITC = 2;
    localparam int         DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset, enable, write, i2c_busy, tx_pop, rx_push;
    logic [1:0] sel;
    logic [7:0] addr, wdata, rdata, tx_data, rx_data;
    logic       ready, i2c_en, i2c_go, tx_valid;
    logic [6:0] i2c_addr;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Reference model state
    logic [7:0] m_tx[$];
    logic [7:0] m_rx[$];
    logic       m_en = 1'b0, m_err = 1'b0, m_ovf = 1'b0;
    logic [6:0] m_slv = 7'd0;

    always #5 clk = ~clk;

    apb_i2c_completer #(
        .SLAVE_ID(SID), .WAIT_CYCLES(WAITC), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .sel(sel), .enable(enable), .write(write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .i2c_en(i2c_en), .i2c_go(i2c_go), .i2c_addr(i2c_addr),
        .i2c_busy(i2c_busy), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_pop(tx_pop), .rx_data(rx_data), .rx_push(rx_push)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] m_status();
        return {1'b0, m_ovf, m_err, i2c_busy,
                m_rx.size() == 0, m_rx.size() == DEPTH,
                m_tx.size() == 0, m_tx.size() == DEPTH};
    endfunction

    function automatic void m_write(input logic [7:0] a, input logic [7:0] d);
        case (a)
            8'h00: m_en = d[0];
            8'h01: begin
                if (d[5]) m_err = 1'b0;
                if (d[6]) m_ovf = 1'b0;
            end
            8'h02: if (m_tx.size() == DEPTH) m_err = 1'b1; else m_tx.push_back(d);
            8'h03: ;
            8'h04: m_slv = d[6:0];
            default: m_err = 1'b1;
        endcase
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        logic [7:0] v;
        v = 8'h00;
        case (a)
            8'h00: v = {7'b0, m_en};
            8'h01: v = m_status();
            8'h02: v = 8'h00;
            8'h03: if (m_rx.size() == 0) m_err = 1'b1; else v = m_rx.pop_front();
            8'h04: v = {1'b0, m_slv};
            default: m_err = 1'b1;
        endcase
        return v;
    endfunction

    // One APB transfer; returns in the cycle where ready is high.
    task automatic apb(input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input int hold, output logic [7:0] rd, output logic go_seen);
        int lat;
        sel = SID; enable = 1'b0; write = wr; addr = a; wdata = d;
        tick();
        enable = 1'b1;
        tick();
        lat = 0;
        while (ready !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check("ready_latency", lat, WAITC + 1);
        rd = rdata;
        go_seen = i2c_go;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("ready_one_cycle_hold", ready, 1'b0);
        end
    endtask

    task automatic idle();
        sel = 2'b00; enable = 1'b0;
        tick();
        check("ready_one_cycle", ready, 1'b0);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d, input int hold);
        logic [7:0] rd;
        logic g;
        apb(1'b1, a, d, hold, rd, g);
        m_write(a, d);
        idle();
    endtask

    task automatic bus_read(input logic [7:0] a, input string tag);
        logic [7:0] rd, exp;
        logic g;
        exp = m_read(a);
        apb(1'b0, a, 8'h00, 0, rd, g);
        check(tag, rd, exp);
        idle();
    endtask

    task automatic pop_tx();
        check("tx_valid_before_pop", tx_valid, 1'b1);
        check("tx_data_head", tx_data, m_tx[0]);
        tx_pop = 1'b1;
        tick();
        tx_pop = 1'b0;
        void'(m_tx.pop_front());
    endtask

    task automatic push_rx(input logic [7:0] v);
        rx_data = v; rx_push = 1'b1;
        tick();
        rx_push = 1'b0;
        if (m_rx.size() == DEPTH) m_ovf = 1'b1; else m_rx.push_back(v);
    endtask

    initial begin
        logic [7:0] rd, v;
        logic       g;
        logic       any_ready;
        int         op;

        reset = 1'b1; sel = 2'b00; enable = 1'b0; write = 1'b0; addr = 8'h00;
        wdata = 8'h00; i2c_busy = 1'b0; tx_pop = 1'b0; rx_push = 1'b0; rx_data = 8'h00;
        tick(); tick();
        check("rst_ready", ready, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_i2c_en", i2c_en, 1'b0);
        check("rst_i2c_go", i2c_go, 1'b0);
        check("rst_i2c_addr", i2c_addr, 7'd0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        reset = 1'b0;
        tick();

        // Reset in the middle of an ACCESS phase discards the transfer.
        sel = SID; enable = 1'b0; write = 1'b1; addr = 8'h02; wdata = 8'h99;
        tick();
        enable = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        any_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (ready === 1'b1) any_ready = 1'b1;
            tick();
        end
        check("ready_after_mid_reset", any_ready, 1'b0);
        idle();
        check("tx_valid_after_mid_reset", tx_valid, 1'b0);
        bus_read(8'h01, "status_after_reset");
        check("status_model_reset", m_status(), 8'h0A);

        // CTRL write with EN and GO.
        apb(1'b1, 8'h00, 8'h03, 0, rd, g);
        m_write(8'h00, 8'h03);
        check("go_pulse", g, 1'b1);
        check("i2c_en_set", i2c_en, 1'b1);
        idle();
        check("go_one_cycle", i2c_go, 1'b0);
        bus_read(8'h00, "ctrl_readback");

        // SLVADDR.
        v = 8'($urandom);
        bus_write(8'h04, v, 0);
        check("i2c_addr", i2c_addr, m_slv);
        bus_read(8'h04, "slvaddr_readback");

        // TX overflow.
        for (int i = 1; i <= 5; i++) bus_write(8'h02, 8'(i * 8'h11), 0);
        bus_read(8'h01, "status_tx_full_err");
        for (int i = 0; i < 4; i++) pop_tx();
        check("tx_valid_drained", tx_valid, 1'b0);
        bus_write(8'h01, 8'h20, 0);

        // RX overflow and underflow.
        for (int i = 0; i < 5; i++) push_rx(8'(8'hA0 + i));
        bus_read(8'h01, "status_rx_ovf");
        for (int i = 0; i < 5; i++) bus_read(8'h03, "rxdata_read");
        bus_read(8'h01, "status_rx_err");
        bus_write(8'h01, 8'h60, 0);
        bus_read(8'h01, "status_cleared");

        // Enable held past ready, then back-to-back transfers.
        bus_write(8'h02, 8'($urandom), 2);
        bus_read(8'h01, "status_one_push");
        pop_tx();
        check("tx_valid_single_push", tx_valid, 1'b0);
        v = 8'($urandom);
        apb(1'b1, 8'h02, v, 0, rd, g);
        m_write(8'h02, v);
        v = 8'($urandom);
        apb(1'b1, 8'h02, v, 0, rd, g);
        m_write(8'h02, v);
        v = m_read(8'h01);
        apb(1'b0, 8'h01, 8'h00, 0, rd, g);
        check("b2b_status", rd, v);
        idle();
        pop_tx();
        pop_tx();

        // Another slave selected: no completion, no register change.
        sel = 2'b10; enable = 1'b0; write = 1'b1; addr = 8'h04; wdata = 8'h7F;
        tick();
        enable = 1'b1;
        any_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ready === 1'b1) any_ready = 1'b1;
        end
        check("foreign_sel_ready", any_ready, 1'b0);
        idle();
        check("foreign_sel_i2c_addr", i2c_addr, m_slv);
        bus_read(8'h04, "foreign_sel_slvaddr");
        bus_read(8'h07, "bad_addr_read");
        bus_read(8'h01, "status_bad_addr_err");
        bus_write(8'h01, 8'h60, 0);

        // Randomized mix.
        for (int it = 0; it < 60; it++) begin
            i2c_busy = 1'($urandom_range(0, 1));
            op = int'($urandom_range(0, 3));
            case (op)
                0: begin
                    bus_write(8'($urandom_range(0, 7)), 8'($urandom), int'($urandom_range(0, 1)));
                    check("rand_i2c_en", i2c_en, m_en);
                    check("rand_i2c_addr", i2c_addr, m_slv);
                end
                1: bus_read(8'($urandom_range(0, 7)), "rand_read");
                2: begin
                    if (m_tx.size() > 0) pop_tx();
                    else check("rand_tx_valid_empty", tx_valid, 1'b0);
                end
                default: push_rx(8'($urandom));
            endcase
        end
        bus_read(8'h01, "final_status");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
